// File: rtl/rob_alloc_ctrl_if.sv
// Handshake bundle between dispatch/writeback/retire and the ROB allocation controller.
// master = surrounding pipeline, slave = rob_alloc_ctrl.
interface rob_alloc_ctrl_if #(
  parameter int DEPTH = 16,
  parameter int TAG_W = $clog2(DEPTH)
);
  logic             enq_valid_i;
  logic             enq_ready_o;
  logic [TAG_W-1:0] enq_tag_o;
  logic             cmpl_valid_i;
  logic [TAG_W-1:0] cmpl_tag_i;
  logic             commit_valid_o;
  logic [TAG_W-1:0] commit_tag_o;
  logic             commit_ready_i;
  logic             flush_i;
  logic [DEPTH-1:0] alloc_we_o;
  logic [DEPTH-1:0] done_we_o;
  logic [DEPTH-1:0] free_we_o;
  logic [TAG_W:0]   count_o;
  logic             full_o;
  logic             empty_o;

  modport master (
    output enq_valid_i, cmpl_valid_i, cmpl_tag_i, commit_ready_i, flush_i,
    input  enq_ready_o, enq_tag_o, commit_valid_o, commit_tag_o,
           alloc_we_o, done_we_o, free_we_o, count_o, full_o, empty_o
  );

  modport slave (
    input  enq_valid_i, cmpl_valid_i, cmpl_tag_i, commit_ready_i, flush_i,
    output enq_ready_o, enq_tag_o, commit_valid_o, commit_tag_o,
           alloc_we_o, done_we_o, free_we_o, count_o, full_o, empty_o
  );
endinterface

// File: rtl/rob_alloc_ctrl.sv
// ROB allocation controller: in-order allocate, out-of-order complete, in-order commit.
// Per-entry valid/done tracking and write-enable generation live in rob_alloc_entry.
module rob_alloc_entry (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic alloc_sel,
  input  logic cmpl_sel,
  input  logic free_sel,
  output logic valid,
  output logic done,
  output logic alloc_we,
  output logic done_we,
  output logic free_we
);
  // Completion only lands on a live, not-yet-done entry; flush squashes it.
  assign alloc_we = alloc_sel;
  assign done_we  = cmpl_sel & valid & ~done & ~flush;
  assign free_we  = flush ? valid : free_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      done  <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
      done  <= 1'b0;
    end else if (alloc_we) begin
      valid <= 1'b1;
      done  <= 1'b0;
    end else if (free_we) begin
      valid <= 1'b0;
      done  <= 1'b0;
    end else if (done_we) begin
      done  <= 1'b1;
    end
  end
endmodule

module rob_alloc_ctrl #(
  parameter int DEPTH = 16,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input logic             clk,
  input logic             rst,
  rob_alloc_ctrl_if.slave bus
);
  localparam logic [TAG_W:0] DEPTH_C = (TAG_W+1)'(DEPTH);

  logic [TAG_W-1:0] head, tail;
  logic [TAG_W:0]   count;
  logic [DEPTH-1:0] valid, done;
  logic [DEPTH-1:0] alloc_we, done_we, free_we;
  logic             enq_ready, enq_fire, commit_valid, commit_fire;

  // No commit bypass: a full buffer refuses enqueue regardless of retire.
  assign enq_ready    = (count < DEPTH_C) & ~bus.flush_i;
  assign enq_fire     = bus.enq_valid_i & enq_ready;
  assign commit_valid = valid[head] & done[head];
  assign commit_fire  = commit_valid & bus.commit_ready_i & ~bus.flush_i;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    rob_alloc_entry u_ent (
      .clk       (clk),
      .rst       (rst),
      .flush     (bus.flush_i),
      .alloc_sel (enq_fire && (tail == TAG_W'(i))),
      .cmpl_sel  (bus.cmpl_valid_i && (bus.cmpl_tag_i == TAG_W'(i))),
      .free_sel  (commit_fire && (head == TAG_W'(i))),
      .valid     (valid[i]),
      .done      (done[i]),
      .alloc_we  (alloc_we[i]),
      .done_we   (done_we[i]),
      .free_we   (free_we[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (bus.flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq_fire)    tail <= tail + TAG_W'(1);
      if (commit_fire) head <= head + TAG_W'(1);
      case ({enq_fire, commit_fire})
        2'b10:   count <= count + (TAG_W+1)'(1);
        2'b01:   count <= count - (TAG_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign bus.enq_ready_o    = enq_ready;
  assign bus.enq_tag_o      = tail;
  assign bus.commit_valid_o = commit_valid;
  assign bus.commit_tag_o   = head;
  assign bus.alloc_we_o     = alloc_we;
  assign bus.done_we_o      = done_we;
  assign bus.free_we_o      = free_we;
  assign bus.count_o        = count;
  assign bus.full_o         = (count == DEPTH_C);
  assign bus.empty_o        = (count == '0);
endmodule

// File: tb/tb_rob_alloc_ctrl.sv
// Directed bench for rob_alloc_ctrl: vector table plus hand sequences for wrap, full/commit, flush, async reset.
module tb_rob_alloc_ctrl;
  localparam int D  = 16;
  localparam int TW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errs = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  rob_alloc_ctrl_if #(.DEPTH(D)) bus ();
  rob_alloc_ctrl #(.DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic          rs, enq, cv;
    logic [TW-1:0] ct;
    logic          cr, fl;
    logic          e_rdy;
    logic [TW-1:0] e_tag;
    logic          e_cv;
    logic [TW-1:0] e_ctag;
    logic [D-1:0]  e_al, e_dn, e_fr;
    logic [TW:0]   e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rs, logic enq, logic cv, int ct, logic cr, logic fl,
                              logic e_rdy, int e_tag, logic e_cv, int e_ctag,
                              logic [D-1:0] e_al, logic [D-1:0] e_dn, logic [D-1:0] e_fr, int e_cnt);
    vec_t v;
    v.rs = rs; v.enq = enq; v.cv = cv; v.ct = TW'(ct); v.cr = cr; v.fl = fl;
    v.e_rdy = e_rdy; v.e_tag = TW'(e_tag); v.e_cv = e_cv; v.e_ctag = TW'(e_ctag);
    v.e_al = e_al; v.e_dn = e_dn; v.e_fr = e_fr; v.e_cnt = (TW+1)'(e_cnt);
    return v;
  endfunction

  task automatic cmp(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(logic enq, logic cv, int ct, logic cr, logic fl);
    bus.enq_valid_i    = enq;
    bus.cmpl_valid_i   = cv;
    bus.cmpl_tag_i     = TW'(ct);
    bus.commit_ready_i = cr;
    bus.flush_i        = fl;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    next_cyc();
  endtask

  // Invariants on every sampled cycle outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (((bus.alloc_we_o & bus.done_we_o) | (bus.alloc_we_o & bus.free_we_o) |
           (bus.done_we_o & bus.free_we_o)) != '0 ||
          $countones(dut.valid) != int'(bus.count_o) || bus.count_o > 5'(D)) begin
        errs++;
        $display("FAIL invariant: al=%0h dn=%0h fr=%0h valid=%0h count=%0d",
                 bus.alloc_we_o, bus.done_we_o, bus.free_we_o, dut.valid, bus.count_o);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state, then 16 back-to-back enqueues and the full idle cycle.
    tbl.push_back(mk(1,0,0,0,0,0, 1,0,0,0, 16'h0,16'h0,16'h0,0));
    for (int i = 0; i < 16; i++)
      tbl.push_back(mk(0,1,0,0,0,0, 1,i,0,0, 16'(1 << i),16'h0,16'h0,i));
    tbl.push_back(mk(0,1,0,0,0,0, 0,0,0,0, 16'h0,16'h0,16'h0,16));
    // Out-of-order completion from full; head retires 0,1 and stops at 2.
    tbl.push_back(mk(0,0,1,3,0,0, 0,0,0,0, 16'h0,16'h0008,16'h0,16));
    tbl.push_back(mk(0,0,1,0,0,0, 0,0,0,0, 16'h0,16'h0001,16'h0,16));
    tbl.push_back(mk(0,0,1,1,1,0, 0,0,1,0, 16'h0,16'h0002,16'h0001,16));
    tbl.push_back(mk(0,0,0,0,1,0, 1,0,1,1, 16'h0,16'h0,16'h0002,15));
    tbl.push_back(mk(0,0,0,0,1,0, 1,0,0,2, 16'h0,16'h0,16'h0,14));
    // Completion to invalid tag 5 and to an already-done entry is ignored.
    tbl.push_back(mk(1,0,0,0,0,0, 1,0,0,0, 16'h0,16'h0,16'h0,0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0,1,1,5,0,0, 1,i,0,0, 16'(1 << i),16'h0,16'h0,i));
    tbl.push_back(mk(0,0,1,1,0,0, 1,3,0,0, 16'h0,16'h0002,16'h0,3));
    tbl.push_back(mk(0,0,1,1,1,0, 1,3,0,0, 16'h0,16'h0,16'h0,3));
    tbl.push_back(mk(0,0,1,5,1,0, 1,3,0,0, 16'h0,16'h0,16'h0,3));

    drive(0, 0, 0, 0, 0);
    next_cyc();
    foreach (tbl[k]) begin
      rst = tbl[k].rs;
      drive(tbl[k].enq, tbl[k].cv, int'(tbl[k].ct), tbl[k].cr, tbl[k].fl);
      @(negedge clk);
      cmp($sformatf("v%0d enq_ready", k),  bus.enq_ready_o,    tbl[k].e_rdy);
      cmp($sformatf("v%0d enq_tag", k),    bus.enq_tag_o,      tbl[k].e_tag);
      cmp($sformatf("v%0d commit_vld", k), bus.commit_valid_o, tbl[k].e_cv);
      cmp($sformatf("v%0d commit_tag", k), bus.commit_tag_o,   tbl[k].e_ctag);
      cmp($sformatf("v%0d alloc_we", k),   bus.alloc_we_o,     tbl[k].e_al);
      cmp($sformatf("v%0d done_we", k),    bus.done_we_o,      tbl[k].e_dn);
      cmp($sformatf("v%0d free_we", k),    bus.free_we_o,      tbl[k].e_fr);
      cmp($sformatf("v%0d count", k),      bus.count_o,        tbl[k].e_cnt);
      cmp($sformatf("v%0d full", k),       bus.full_o,         tbl[k].e_cnt == 5'(D));
      cmp($sformatf("v%0d empty", k),      bus.empty_o,        tbl[k].e_cnt == 5'd0);
      next_cyc();
    end
    rst = 1'b0;

    // Pointer wrap at steady occupancy 2.
    do_reset();
    drive(1, 0, 0, 0, 0); next_cyc();
    drive(1, 1, 0, 0, 0); next_cyc();
    for (int k = 2; k < 22; k++) begin
      drive(1, 1, (k-1) % 16, 1, 0);
      @(negedge clk);
      cmp($sformatf("wrap%0d enq_tag", k),    bus.enq_tag_o,      64'(k % 16));
      cmp($sformatf("wrap%0d commit_vld", k), bus.commit_valid_o, 64'd1);
      cmp($sformatf("wrap%0d commit_tag", k), bus.commit_tag_o,   64'((k-2) % 16));
      cmp($sformatf("wrap%0d alloc_we", k),   bus.alloc_we_o,     64'(1 << (k % 16)));
      cmp($sformatf("wrap%0d done_we", k),    bus.done_we_o,      64'(1 << ((k-1) % 16)));
      cmp($sformatf("wrap%0d free_we", k),    bus.free_we_o,      64'(1 << ((k-2) % 16)));
      cmp($sformatf("wrap%0d count", k),      bus.count_o,        64'd2);
      next_cyc();
    end

    // Full with head done: commit fires, enqueue refused.
    do_reset();
    for (int i = 0; i < 16; i++) begin drive(1, 0, 0, 0, 0); next_cyc(); end
    drive(0, 1, 0, 0, 0); next_cyc();
    drive(1, 0, 0, 1, 0);
    @(negedge clk);
    cmp("full enq_ready",  bus.enq_ready_o,    64'd0);
    cmp("full commit_vld", bus.commit_valid_o, 64'd1);
    cmp("full alloc_we",   bus.alloc_we_o,     64'd0);
    cmp("full free_we",    bus.free_we_o,      64'h0001);
    next_cyc();
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    cmp("full+1 count",     bus.count_o,     64'd15);
    cmp("full+1 enq_ready", bus.enq_ready_o, 64'd1);
    cmp("full+1 enq_tag",   bus.enq_tag_o,   64'd0);
    next_cyc();

    // Flush at occupancy 7 with concurrent enqueue, completion and retire.
    do_reset();
    for (int i = 0; i < 7; i++) begin drive(1, 0, 0, 0, 0); next_cyc(); end
    drive(0, 1, 0, 0, 0); next_cyc();
    drive(1, 1, 2, 1, 1);
    @(negedge clk);
    cmp("flush free_we",   bus.free_we_o,   64'h007F);
    cmp("flush alloc_we",  bus.alloc_we_o,  64'd0);
    cmp("flush done_we",   bus.done_we_o,   64'd0);
    cmp("flush enq_ready", bus.enq_ready_o, 64'd0);
    next_cyc();
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    cmp("flush+1 count",   bus.count_o,   64'd0);
    cmp("flush+1 empty",   bus.empty_o,   64'd1);
    cmp("flush+1 enq_tag", bus.enq_tag_o, 64'd0);
    cmp("flush+1 commit_tag", bus.commit_tag_o, 64'd0);
    next_cyc();

    // Async reset mid-cycle discards live state without a clock edge.
    for (int i = 0; i < 3; i++) begin drive(1, 0, 0, 0, 0); next_cyc(); end
    drive(0, 1, 0, 0, 0); next_cyc();
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    cmp("pre-rst count",      bus.count_o,        64'd3);
    cmp("pre-rst commit_vld", bus.commit_valid_o, 64'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    cmp("arst count",      bus.count_o,        64'd0);
    cmp("arst empty",      bus.empty_o,        64'd1);
    cmp("arst full",       bus.full_o,         64'd0);
    cmp("arst enq_ready",  bus.enq_ready_o,    64'd1);
    cmp("arst enq_tag",    bus.enq_tag_o,      64'd0);
    cmp("arst commit_vld", bus.commit_valid_o, 64'd0);
    cmp("arst commit_tag", bus.commit_tag_o,   64'd0);
    cmp("arst free_we",    bus.free_we_o,      64'd0);
    #1;
    rst = 1'b0;
    next_cyc();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
